control_pipe: RTL

CONTROL_PIPE -- requirements
Module: control_pipe

---
 rtl/ctrl_pkg.sv | 87 ++++++++
 rtl/ctrl_decode.sv | 37 +++
 rtl/control_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the decode-to-execute control pipeline:
// control bundle layout, opcode classes, per-class control presets and FSM states.
package ctrl_pkg;

  typedef struct packed {
    logic [1:0] ImSel;
    logic       jump;
    logic       branch;
    logic       Alusrc1;
    logic       Alusrc2;
    logic       regWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       H_sel;
    logic       csr;
    logic [1:0] wr_sel;
    logic [2:0] ALUop;
    logic       fence;
    logic       illegal;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef enum logic {
    RUN,
    DRAIN
  } pipe_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Immediate format; U-type is ImSel=IMM_I with H_sel=1
  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  localparam logic [1:0] WR_ALU = 2'd0;
  localparam logic [1:0] WR_MEM = 2'd1;
  localparam logic [1:0] WR_PC4 = 2'd2;
  localparam logic [1:0] WR_CSR = 2'd3;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_BR     = 3'd1;
  localparam logic [2:0] ALU_RR     = 3'd2;
  localparam logic [2:0] ALU_RR_ALT = 3'd3;
  localparam logic [2:0] ALU_RI     = 3'd4;
  localparam logic [2:0] ALU_RI_ALT = 3'd5;
  localparam logic [2:0] ALU_PASS   = 3'd6;

  localparam ctrl_t CTRL_ILLEGAL = '{illegal: 1'b1, default: '0};

  localparam ctrl_t CTRL_LOAD = '{ImSel: IMM_I, Alusrc2: 1'b1, regWrite: 1'b1, MemRead: 1'b1,
                                  wr_sel: WR_MEM, ALUop: ALU_ADD, default: '0};
  localparam ctrl_t CTRL_STORE = '{ImSel: IMM_S, Alusrc2: 1'b1, MemWrite: 1'b1,
                                   ALUop: ALU_ADD, default: '0};
  localparam ctrl_t CTRL_OP = '{regWrite: 1'b1, wr_sel: WR_ALU, ALUop: ALU_RR, default: '0};
  localparam ctrl_t CTRL_OP_IMM = '{ImSel: IMM_I, Alusrc2: 1'b1, regWrite: 1'b1,
                                    wr_sel: WR_ALU, ALUop: ALU_RI, default: '0};
  localparam ctrl_t CTRL_LUI = '{H_sel: 1'b1, Alusrc2: 1'b1, regWrite: 1'b1,
                                 wr_sel: WR_ALU, ALUop: ALU_PASS, default: '0};
  localparam ctrl_t CTRL_AUIPC = '{H_sel: 1'b1, Alusrc1: 1'b1, Alusrc2: 1'b1, regWrite: 1'b1,
                                   wr_sel: WR_ALU, ALUop: ALU_ADD, default: '0};
  localparam ctrl_t CTRL_JAL = '{ImSel: IMM_J, jump: 1'b1, Alusrc1: 1'b1, Alusrc2: 1'b1,
                                 regWrite: 1'b1, wr_sel: WR_PC4, ALUop: ALU_ADD, default: '0};
  localparam ctrl_t CTRL_JALR = '{ImSel: IMM_I, jump: 1'b1, Alusrc2: 1'b1, regWrite: 1'b1,
                                  wr_sel: WR_PC4, ALUop: ALU_ADD, default: '0};
  localparam ctrl_t CTRL_BRANCH = '{ImSel: IMM_B, branch: 1'b1, ALUop: ALU_BR, default: '0};
  localparam ctrl_t CTRL_SYSTEM = '{ImSel: IMM_I, csr: 1'b1, regWrite: 1'b1,
                                    wr_sel: WR_CSR, ALUop: ALU_ADD, default: '0};
  localparam ctrl_t CTRL_FENCE = '{fence: 1'b1, default: '0};

  // Classes whose rs2 field is a real source operand
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps opcode/invert onto the control bundle,
// flagging any unrecognised or non-32-bit encoding as illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       invert,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_ILLEGAL;
    if (opcode[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD:   ctrl = CTRL_LOAD;
        OPC_STORE:  ctrl = CTRL_STORE;
        OPC_OP: begin
          ctrl       = CTRL_OP;
          ctrl.ALUop = invert ? ALU_RR_ALT : ALU_RR;
        end
        OPC_OP_IMM: begin
          ctrl       = CTRL_OP_IMM;
          ctrl.ALUop = invert ? ALU_RI_ALT : ALU_RI;
        end
        OPC_LUI:    ctrl = CTRL_LUI;
        OPC_AUIPC:  ctrl = CTRL_AUIPC;
        OPC_JAL:    ctrl = CTRL_JAL;
        OPC_JALR:   ctrl = CTRL_JALR;
        OPC_BRANCH: ctrl = CTRL_BRANCH;
        OPC_SYSTEM: ctrl = CTRL_SYSTEM;
        OPC_FENCE:  ctrl = CTRL_FENCE;
        default:    ctrl = CTRL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Decoded-control shift pipeline with load-use stall, flush and fence drain.
// Define CTRL_PIPE_PERF_EN to build the saturating stall/flush performance counters.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned RA_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic                     invert,
  input  logic [RA_W-1:0]          rd,
  input  logic [RA_W-1:0]          rs1,
  input  logic [RA_W-1:0]          rs2,
  input  logic                     flush,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [STAGES*RA_W-1:0]   stage_rd,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt
);

  ctrl_t dec_ctrl;

  ctrl_decode u_decode (
    .opcode (opcode),
    .invert (invert),
    .ctrl   (dec_ctrl)
  );

  logic [STAGES-1:0]           valid_q, valid_d;
  ctrl_t [STAGES-1:0]          ctrl_q, ctrl_d;
  logic [STAGES-1:0][RA_W-1:0] rd_q, rd_d;
  pipe_state_e                 state_q, state_d;

  logic load_use;
  logic any_valid;
  logic accept;

  always_comb begin
    load_use  = valid_q[0] && ctrl_q[0].MemRead && (rd_q[0] != '0) &&
                ((rd_q[0] == rs1) || (uses_rs2(opcode) && (rd_q[0] == rs2)));
    any_valid = |valid_q;

    in_ready = 1'b0;
    if (reset) begin
      if (state_q == DRAIN) begin
        in_ready = ~any_valid;
      end else begin
        // A flush kills the dependent instruction, so there is nothing to stall
        in_ready = ~load_use | flush;
      end
    end

    accept = in_valid & in_ready & ~flush;
  end

  always_comb begin
    state_d = state_q;
    if (accept && dec_ctrl.fence) begin
      state_d = DRAIN;
    end else if ((state_q == DRAIN) && !any_valid) begin
      state_d = RUN;
    end
  end

  always_comb begin
    valid_d   = '0;
    ctrl_d    = '0;
    rd_d      = '0;
    valid_d[0] = accept;
    ctrl_d[0]  = accept ? dec_ctrl : '0;
    rd_d[0]    = accept ? rd : '0;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      ctrl_d[k]  = ctrl_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      state_q <= RUN;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      state_q <= state_d;
    end
  end

  assign stage_valid = valid_q;
  assign stage_ctrl  = ctrl_q;
  assign stage_rd    = rd_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (in_valid && !in_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && in_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
